// File: rtl/axi4l_arbiter_2to1.sv
// Two-to-one AXI4-Lite arbiter. Write and read channels are owned independently, one transaction each.
// Define AXI4L_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise s0 has fixed priority.
module axi4l_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  // requester 0
  input  logic [ADDR_WIDTH-1:0]   s0_awaddr_i,
  input  logic [2:0]              s0_awprot_i,
  input  logic                    s0_awvalid_i,
  output logic                    s0_awready_o,
  input  logic [DATA_WIDTH-1:0]   s0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s0_wstrb_i,
  input  logic                    s0_wvalid_i,
  output logic                    s0_wready_o,
  output logic [1:0]              s0_bresp_o,
  output logic                    s0_bvalid_o,
  input  logic                    s0_bready_i,
  input  logic [ADDR_WIDTH-1:0]   s0_araddr_i,
  input  logic [2:0]              s0_arprot_i,
  input  logic                    s0_arvalid_i,
  output logic                    s0_arready_o,
  output logic [DATA_WIDTH-1:0]   s0_rdata_o,
  output logic [1:0]              s0_rresp_o,
  output logic                    s0_rvalid_o,
  input  logic                    s0_rready_i,
  // requester 1
  input  logic [ADDR_WIDTH-1:0]   s1_awaddr_i,
  input  logic [2:0]              s1_awprot_i,
  input  logic                    s1_awvalid_i,
  output logic                    s1_awready_o,
  input  logic [DATA_WIDTH-1:0]   s1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb_i,
  input  logic                    s1_wvalid_i,
  output logic                    s1_wready_o,
  output logic [1:0]              s1_bresp_o,
  output logic                    s1_bvalid_o,
  input  logic                    s1_bready_i,
  input  logic [ADDR_WIDTH-1:0]   s1_araddr_i,
  input  logic [2:0]              s1_arprot_i,
  input  logic                    s1_arvalid_i,
  output logic                    s1_arready_o,
  output logic [DATA_WIDTH-1:0]   s1_rdata_o,
  output logic [1:0]              s1_rresp_o,
  output logic                    s1_rvalid_o,
  input  logic                    s1_rready_i,
  // shared downstream port
  output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
  output logic [2:0]              m_awprot_o,
  output logic                    m_awvalid_o,
  input  logic                    m_awready_i,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
  output logic                    m_wvalid_o,
  input  logic                    m_wready_i,
  input  logic [1:0]              m_bresp_i,
  input  logic                    m_bvalid_i,
  output logic                    m_bready_o,
  output logic [ADDR_WIDTH-1:0]   m_araddr_o,
  output logic [2:0]              m_arprot_o,
  output logic                    m_arvalid_o,
  input  logic                    m_arready_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  input  logic [1:0]              m_rresp_i,
  input  logic                    m_rvalid_i,
  output logic                    m_rready_o,
  output logic [1:0]              wr_grant,
  output logic [1:0]              rd_grant
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} own_e;

  own_e wr_state_q, wr_state_d, rd_state_q, rd_state_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d, ar_done_q, ar_done_d;
  logic wr_req0, wr_req1, rd_req0, rd_req1;
  logic wr_own0, wr_own1, rd_own0, rd_own1;
  logic wr_pick1, rd_pick1;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign wr_req0 = s0_awvalid_i | s0_wvalid_i;
  assign wr_req1 = s1_awvalid_i | s1_wvalid_i;
  assign rd_req0 = s0_arvalid_i;
  assign rd_req1 = s1_arvalid_i;

  assign wr_own0  = (wr_state_q == OWN0);
  assign wr_own1  = (wr_state_q == OWN1);
  assign rd_own0  = (rd_state_q == OWN0);
  assign rd_own1  = (rd_state_q == OWN1);
  assign wr_grant = {wr_own1, wr_own0};
  assign rd_grant = {rd_own1, rd_own0};

  // Write path: everything to m is zero while idle; done flags mask repeat beats.
  assign m_awaddr_o  = wr_own0 ? s0_awaddr_i : (wr_own1 ? s1_awaddr_i : '0);
  assign m_awprot_o  = wr_own0 ? s0_awprot_i : (wr_own1 ? s1_awprot_i : '0);
  assign m_wdata_o   = wr_own0 ? s0_wdata_i  : (wr_own1 ? s1_wdata_i  : '0);
  assign m_wstrb_o   = wr_own0 ? s0_wstrb_i  : (wr_own1 ? s1_wstrb_i  : '0);
  assign m_awvalid_o = ~aw_done_q & ((wr_own0 & s0_awvalid_i) | (wr_own1 & s1_awvalid_i));
  assign m_wvalid_o  = ~w_done_q  & ((wr_own0 & s0_wvalid_i)  | (wr_own1 & s1_wvalid_i));
  assign m_bready_o  = (wr_own0 & s0_bready_i) | (wr_own1 & s1_bready_i);

  assign s0_awready_o = wr_own0 & ~aw_done_q & m_awready_i;
  assign s1_awready_o = wr_own1 & ~aw_done_q & m_awready_i;
  assign s0_wready_o  = wr_own0 & ~w_done_q & m_wready_i;
  assign s1_wready_o  = wr_own1 & ~w_done_q & m_wready_i;
  assign s0_bvalid_o  = wr_own0 & m_bvalid_i;
  assign s1_bvalid_o  = wr_own1 & m_bvalid_i;
  assign s0_bresp_o   = wr_own0 ? m_bresp_i : 2'b00;
  assign s1_bresp_o   = wr_own1 ? m_bresp_i : 2'b00;

  assign m_araddr_o  = rd_own0 ? s0_araddr_i : (rd_own1 ? s1_araddr_i : '0);
  assign m_arprot_o  = rd_own0 ? s0_arprot_i : (rd_own1 ? s1_arprot_i : '0);
  assign m_arvalid_o = ~ar_done_q & ((rd_own0 & s0_arvalid_i) | (rd_own1 & s1_arvalid_i));
  assign m_rready_o  = (rd_own0 & s0_rready_i) | (rd_own1 & s1_rready_i);

  assign s0_arready_o = rd_own0 & ~ar_done_q & m_arready_i;
  assign s1_arready_o = rd_own1 & ~ar_done_q & m_arready_i;
  assign s0_rvalid_o  = rd_own0 & m_rvalid_i;
  assign s1_rvalid_o  = rd_own1 & m_rvalid_i;
  assign s0_rdata_o   = rd_own0 ? m_rdata_i : '0;
  assign s1_rdata_o   = rd_own1 ? m_rdata_i : '0;
  assign s0_rresp_o   = rd_own0 ? m_rresp_i : 2'b00;
  assign s1_rresp_o   = rd_own1 ? m_rresp_i : 2'b00;

  assign aw_hs = m_awvalid_o & m_awready_i;
  assign w_hs  = m_wvalid_o & m_wready_i;
  assign b_hs  = m_bvalid_i & m_bready_o;
  assign ar_hs = m_arvalid_o & m_arready_i;
  assign r_hs  = m_rvalid_i & m_rready_o;

`ifdef AXI4L_ARB_ROUND_ROBIN_EN
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  // Write pointer moves to the requester that just lost; read pointer simply toggles.
  assign wr_ptr_d = b_hs ? wr_own0 : wr_ptr_q;
  assign rd_ptr_d = r_hs ? ~rd_ptr_q : rd_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign wr_pick1 = wr_ptr_q;
  assign rd_pick1 = rd_ptr_q;
`else
  assign wr_pick1 = 1'b0;
  assign rd_pick1 = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= IDLE;
      rd_state_q <= IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      ar_done_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      ar_done_q  <= ar_done_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (wr_state_q)
      IDLE: begin
        if (wr_req0 & (~wr_req1 | ~wr_pick1)) wr_state_d = OWN0;
        else if (wr_req1)                     wr_state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (b_hs) begin
          wr_state_d = IDLE;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      default: wr_state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    ar_done_d  = ar_done_q;
    case (rd_state_q)
      IDLE: begin
        if (rd_req0 & (~rd_req1 | ~rd_pick1)) rd_state_d = OWN0;
        else if (rd_req1)                     rd_state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (ar_hs) ar_done_d = 1'b1;
        if (r_hs) begin
          rd_state_d = IDLE;
          ar_done_d  = 1'b0;
        end
      end
      default: rd_state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4l_arbiter_2to1.sv
// Bench for axi4l_arbiter_2to1: grant-decision vector table plus directed transaction sequences.
module tb_axi4l_arbiter_2to1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata;
  logic [2:0]  s0_awprot, s0_arprot;
  logic [3:0]  s0_wstrb;
  logic [1:0]  s0_bresp, s0_rresp;
  logic s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
  logic s0_arvalid, s0_arready, s0_rvalid, s0_rready;

  logic [31:0] s1_awaddr, s1_wdata, s1_araddr, s1_rdata;
  logic [2:0]  s1_awprot, s1_arprot;
  logic [3:0]  s1_wstrb;
  logic [1:0]  s1_bresp, s1_rresp;
  logic s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
  logic s1_arvalid, s1_arready, s1_rvalid, s1_rready;

  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;

  logic [1:0] wr_grant, rd_grant;

  axi4l_arbiter_2to1 dut (
    .clk(clk), .rst(rst),
    .s0_awaddr_i(s0_awaddr), .s0_awprot_i(s0_awprot), .s0_awvalid_i(s0_awvalid), .s0_awready_o(s0_awready),
    .s0_wdata_i(s0_wdata), .s0_wstrb_i(s0_wstrb), .s0_wvalid_i(s0_wvalid), .s0_wready_o(s0_wready),
    .s0_bresp_o(s0_bresp), .s0_bvalid_o(s0_bvalid), .s0_bready_i(s0_bready),
    .s0_araddr_i(s0_araddr), .s0_arprot_i(s0_arprot), .s0_arvalid_i(s0_arvalid), .s0_arready_o(s0_arready),
    .s0_rdata_o(s0_rdata), .s0_rresp_o(s0_rresp), .s0_rvalid_o(s0_rvalid), .s0_rready_i(s0_rready),
    .s1_awaddr_i(s1_awaddr), .s1_awprot_i(s1_awprot), .s1_awvalid_i(s1_awvalid), .s1_awready_o(s1_awready),
    .s1_wdata_i(s1_wdata), .s1_wstrb_i(s1_wstrb), .s1_wvalid_i(s1_wvalid), .s1_wready_o(s1_wready),
    .s1_bresp_o(s1_bresp), .s1_bvalid_o(s1_bvalid), .s1_bready_i(s1_bready),
    .s1_araddr_i(s1_araddr), .s1_arprot_i(s1_arprot), .s1_arvalid_i(s1_arvalid), .s1_arready_o(s1_arready),
    .s1_rdata_o(s1_rdata), .s1_rresp_o(s1_rresp), .s1_rvalid_o(s1_rvalid), .s1_rready_i(s1_rready),
    .m_awaddr_o(m_awaddr), .m_awprot_o(m_awprot), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
    .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
    .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready),
    .m_araddr_o(m_araddr), .m_arprot_o(m_arprot), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
    .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready),
    .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  // Downstream slave model: always-ready address/data, response one cycle after acceptance.
  logic        sl_ready;
  logic [31:0] sl_rdata;
  logic [1:0]  sl_bresp, sl_rresp;
  logic        aw_got, w_got, aw_now, w_now;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;

  assign m_awready = sl_ready;
  assign m_wready  = sl_ready;
  assign m_arready = sl_ready;
  assign aw_now    = aw_got | (m_awvalid & m_awready);
  assign w_now     = w_got | (m_wvalid & m_wready);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_bvalid <= 1'b0; m_bresp <= 2'b00; aw_got <= 1'b0; w_got <= 1'b0;
      m_rvalid <= 1'b0; m_rresp <= 2'b00; m_rdata <= 32'h0;
    end else begin
      if (m_awvalid & m_awready) aw_cnt <= aw_cnt + 1;
      if (m_wvalid & m_wready)   w_cnt  <= w_cnt + 1;
      if (m_arvalid & m_arready) ar_cnt <= ar_cnt + 1;
      if (m_bvalid & m_bready) begin
        m_bvalid <= 1'b0;
      end else if (aw_now & w_now & !m_bvalid) begin
        m_bvalid <= 1'b1; m_bresp <= sl_bresp; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= aw_now; w_got <= w_now;
      end
      if (m_rvalid & m_rready) m_rvalid <= 1'b0;
      if (m_arvalid & m_arready) begin
        m_rvalid <= 1'b1; m_rdata <= sl_rdata; m_rresp <= sl_rresp;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    s0_awaddr = 32'h100; s0_awprot = 3'd0; s0_awvalid = 0; s0_wdata = 0; s0_wstrb = 4'h0; s0_wvalid = 0;
    s0_bready = 0; s0_araddr = 32'h1000; s0_arprot = 3'd0; s0_arvalid = 0; s0_rready = 0;
    s1_awaddr = 32'h200; s1_awprot = 3'd0; s1_awvalid = 0; s1_wdata = 0; s1_wstrb = 4'h0; s1_wvalid = 0;
    s1_bready = 0; s1_araddr = 32'h2000; s1_arprot = 3'd0; s1_arvalid = 0; s1_rready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  r0, r1;      // {awvalid, wvalid, arvalid}
    logic [1:0]  wg, rg;
    logic        mav, mwv, marv;
    logic [31:0] awaddr, araddr;
  } vec_t;

  vec_t vt[9];
  logic [1:0]  g_own[4];
  int          g_cyc[4];
  int          n_g, base_aw, base_w;
  logic [1:0]  prev_rg, exp_own;

  initial begin
    vt[0] = '{3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
    vt[1] = '{3'b100, 3'b000, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0};
    vt[2] = '{3'b000, 3'b010, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0};
    vt[3] = '{3'b001, 3'b000, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0,   32'h1000};
    vt[4] = '{3'b000, 3'b001, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0,   32'h2000};
    vt[5] = '{3'b001, 3'b001, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0,   32'h1000};
    vt[6] = '{3'b110, 3'b110, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0};
    vt[7] = '{3'b110, 3'b001, 2'b01, 2'b10, 1'b1, 1'b1, 1'b1, 32'h100, 32'h2000};
    vt[8] = '{3'b001, 3'b100, 2'b10, 2'b01, 1'b1, 1'b0, 1'b1, 32'h200, 32'h1000};

    sl_ready = 1'b0; sl_rdata = 32'h0; sl_bresp = 2'b00; sl_rresp = 2'b00;
    idle_inputs();
    rst = 1'b1;
    #3;
    chk("rst_wr_grant", wr_grant, 2'b00);
    chk("rst_rd_grant", rd_grant, 2'b00);
    chk("rst_m_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
    chk("rst_s_outs", {s0_awready, s0_wready, s0_arready, s0_bvalid, s0_rvalid,
                       s1_awready, s1_wready, s1_arready, s1_bvalid, s1_rvalid}, 10'b0);

    // Grant decisions from IDLE (slave held not-ready so nothing completes).
    for (int i = 0; i < 9; i++) begin
      do_reset();
      {s0_awvalid, s0_wvalid, s0_arvalid} = vt[i].r0;
      {s1_awvalid, s1_wvalid, s1_arvalid} = vt[i].r1;
      s0_bready = 1; s1_bready = 1;
      #2;
      chk($sformatf("v%0d_idle_grant", i), {wr_grant, rd_grant}, 4'b0);
      chk($sformatf("v%0d_idle_m", i), {m_awvalid, m_wvalid, m_arvalid, m_bready, m_awaddr != 0, m_araddr != 0}, 6'b0);
      @(posedge clk); #3;
      chk($sformatf("v%0d_wr_grant", i), wr_grant, vt[i].wg);
      chk($sformatf("v%0d_rd_grant", i), rd_grant, vt[i].rg);
      chk($sformatf("v%0d_m_valids", i), {m_awvalid, m_wvalid, m_arvalid}, {vt[i].mav, vt[i].mwv, vt[i].marv});
      chk($sformatf("v%0d_m_awaddr", i), m_awaddr, vt[i].awaddr);
      chk($sformatf("v%0d_m_araddr", i), m_araddr, vt[i].araddr);
    end

    // Single read from s0.
    sl_ready = 1'b1; sl_rdata = 32'hDEADBEEF; sl_rresp = 2'b00;
    do_reset();
    s0_araddr = 32'h0000_1000; s0_arvalid = 1; s0_rready = 1;
    #2 chk("rd_grant_before", rd_grant, 2'b00);
    step(); #2;
    chk("rd_grant_01", rd_grant, 2'b01);
    chk("rd_m_araddr", m_araddr, 32'h1000);
    chk("rd_s0_arready", s0_arready, 1'b1);
    step(); s0_arvalid = 0; #2;
    chk("rd_s0_rvalid", s0_rvalid, 1'b1);
    chk("rd_s0_rdata", s0_rdata, 32'hDEADBEEF);
    chk("rd_s0_rresp", s0_rresp, 2'b00);
    chk("rd_s1_rvalid", s1_rvalid, 1'b0);
    step(); #2;
    chk("rd_grant_00", rd_grant, 2'b00);

    // s1 write, W two cycles before AW; W held high to confirm it is forwarded once.
    sl_bresp = 2'b00;
    do_reset();
    base_aw = aw_cnt; base_w = w_cnt;
    s1_wdata = 32'h1234_5678; s1_wstrb = 4'hF; s1_wvalid = 1; s1_bready = 1;
    #2 chk("wr_grant_before", wr_grant, 2'b00);
    step(); #2;
    chk("wr_grant_10", wr_grant, 2'b10);
    chk("wr_m_wvalid", m_wvalid, 1'b1);
    chk("wr_m_wdata", m_wdata, 32'h1234_5678);
    chk("wr_m_wstrb", m_wstrb, 4'hF);
    chk("wr_m_awvalid_early", m_awvalid, 1'b0);
    step(); s1_awaddr = 32'h2000; s1_awvalid = 1; #2;
    chk("wr_w_masked", m_wvalid, 1'b0);
    chk("wr_s1_wready_masked", s1_wready, 1'b0);
    chk("wr_m_awvalid", m_awvalid, 1'b1);
    chk("wr_m_awaddr", m_awaddr, 32'h2000);
    step(); s1_awvalid = 0; s1_wvalid = 0; #2;
    chk("wr_s1_bvalid", s1_bvalid, 1'b1);
    chk("wr_s1_bresp", s1_bresp, 2'b00);
    chk("wr_s0_bvalid", s0_bvalid, 1'b0);
    chk("wr_grant_held", wr_grant, 2'b10);
    step(); #2;
    chk("wr_grant_00", wr_grant, 2'b00);
    chk("wr_aw_once", aw_cnt - base_aw, 1);
    chk("wr_w_once", w_cnt - base_w, 1);

    // Read contention: both requesters read continuously.
    do_reset();
    s0_arvalid = 1; s1_arvalid = 1; s0_rready = 1; s1_rready = 1;
    n_g = 0; prev_rg = 2'b00;
    for (int c = 0; c < 20; c++) begin
      step(); #2;
      if (rd_grant != 2'b00 && prev_rg == 2'b00 && n_g < 4) begin
        g_own[n_g] = rd_grant; g_cyc[n_g] = c; n_g++;
      end
      prev_rg = rd_grant;
    end
    chk("cont_grant_count", n_g, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_g) begin
`ifdef AXI4L_ARB_ROUND_ROBIN_EN
        exp_own = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
        exp_own = 2'b01;
`endif
        chk($sformatf("cont_owner%0d", i), g_own[i], exp_own);
        chk($sformatf("cont_cycle%0d", i), g_cyc[i], 3 * i);
      end
    end
    s0_arvalid = 0; s1_arvalid = 0;
    step(); step();

    // Concurrent: s0 writes while s1 reads.
    sl_rdata = 32'h0BAD_F00D; sl_bresp = 2'b00;
    do_reset();
    s0_awaddr = 32'h300; s0_awvalid = 1; s0_wdata = 32'hAAAA_5555; s0_wstrb = 4'hF; s0_wvalid = 1; s0_bready = 1;
    s1_araddr = 32'h4000; s1_arvalid = 1; s1_rready = 1;
    step(); #2;
    chk("cc_wr_grant", wr_grant, 2'b01);
    chk("cc_rd_grant", rd_grant, 2'b10);
    chk("cc_m_awaddr", m_awaddr, 32'h300);
    chk("cc_m_araddr", m_araddr, 32'h4000);
    step(); s0_awvalid = 0; s0_wvalid = 0; s1_arvalid = 0; #2;
    chk("cc_bvalid", {s0_bvalid, s1_bvalid}, 2'b10);
    chk("cc_rvalid", {s0_rvalid, s1_rvalid}, 2'b01);
    chk("cc_s1_rdata", s1_rdata, 32'h0BAD_F00D);
    chk("cc_s0_rdata", s0_rdata, 32'h0);
    step(); #2;
    chk("cc_grants_idle", {wr_grant, rd_grant}, 4'b0);

    // DECERR on an s1 write reaches only s1.
    sl_bresp = 2'b11;
    do_reset();
    s1_awaddr = 32'h500; s1_awvalid = 1; s1_wdata = 32'h5; s1_wstrb = 4'h1; s1_wvalid = 1; s1_bready = 1;
    s0_bready = 1;
    step(); step(); s1_awvalid = 0; s1_wvalid = 0; #2;
    chk("err_s1_bvalid", s1_bvalid, 1'b1);
    chk("err_s1_bresp", s1_bresp, 2'b11);
    chk("err_s0_bvalid", s0_bvalid, 1'b0);
    chk("err_s0_bresp", s0_bresp, 2'b00);
    step();
    sl_bresp = 2'b00;

    // Reset between AW acceptance and B, then a clean read.
    do_reset();
    s0_awaddr = 32'h600; s0_awvalid = 1; s0_bready = 1;
    step(); step(); s0_awvalid = 0; #2;
    chk("rstw_owned", wr_grant, 2'b01);
    chk("rstw_m_bready_owned", m_bready, 1'b1);
    rst = 1'b1; #1;
    chk("rstw_wr_grant", wr_grant, 2'b00);
    chk("rstw_m_outs", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 5'b0);
    chk("rstw_m_awaddr", m_awaddr, 32'h0);
    chk("rstw_s0_outs", {s0_awready, s0_wready, s0_bvalid}, 3'b0);
    step(); rst = 1'b0; s0_bready = 0;
    sl_rdata = 32'hCAFE_F00D;
    s0_araddr = 32'h1000; s0_arvalid = 1; s0_rready = 1;
    step(); #2;
    chk("rstw_rd_grant", rd_grant, 2'b01);
    step(); s0_arvalid = 0; #2;
    chk("rstw_s0_rvalid", s0_rvalid, 1'b1);
    chk("rstw_s0_rdata", s0_rdata, 32'hCAFE_F00D);
    step(); #2;
    chk("rstw_rd_idle", rd_grant, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
